// File: rtl/ps2_rx_ctrl.sv
// PS/2 receive controller: pin synchronizer, 11-bit frame FSM, frame checks and valid/ready delivery.
// Optional build macro PS2_RX_PARITY_CHECK_EN enables odd-parity checking and the parity_err pulse.
module ps2_rx_ctrl #(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rx_en,
  input  logic       ready,
  output logic [7:0] data,
  output logic       valid,
  output logic       busy,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t          state_r, state_nxt_s;
  logic            clk_meta_r, clk_sync_r, clk_prev_r;
  logic            data_meta_r, data_sync_r;
  logic            fall_s, timeout_s, parity_bad_s, good_s;
  logic [7:0]      shift_r, shift_nxt_s;
  logic [2:0]      bit_cnt_r, bit_cnt_nxt_s;
  logic [TW-1:0]   timer_r, timer_nxt_s;
  logic [7:0]      data_r, data_nxt_s;
  logic            valid_r, valid_nxt_s;
  logic            busy_r;
  logic            perr_r, perr_nxt_s;
  logic            ferr_r, ferr_nxt_s;
  logic            ovr_r, ovr_nxt_s;

  assign fall_s    = clk_prev_r & ~clk_sync_r;
  assign timeout_s = (timer_r == TIMEOUT_LAST);

`ifdef PS2_RX_PARITY_CHECK_EN
  logic par_bit_r;

  function automatic logic parity_odd(input logic [7:0] b, input logic p);
    return ^{b, p};
  endfunction

  // Capture the parity bit on the fall that closes the PARITY state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_bit_r <= 1'b0;
    end else if (state_r == PARITY && fall_s) begin
      par_bit_r <= data_sync_r;
    end else begin
      par_bit_r <= par_bit_r;
    end
  end

  assign parity_bad_s = ~parity_odd(shift_r, par_bit_r);
`else
  assign parity_bad_s = 1'b0;
`endif

  // Two-flop synchronizers plus the previous-clock flop; all reset high so reset never fakes an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      clk_prev_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= ps2_clk;
      clk_sync_r  <= clk_meta_r;
      clk_prev_r  <= clk_sync_r;
      data_meta_r <= ps2_data;
      data_sync_r <= data_meta_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; dropping rx_en aborts a frame silently.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (rx_en && fall_s && !data_sync_r) state_nxt_s = DATA;
        else                                 state_nxt_s = IDLE;
      end
      DATA: begin
        if (!rx_en)                            state_nxt_s = IDLE;
        else if (fall_s && bit_cnt_r == 3'd7)  state_nxt_s = PARITY;
        else if (fall_s)                       state_nxt_s = DATA;
        else if (timeout_s)                    state_nxt_s = IDLE;
        else                                   state_nxt_s = DATA;
      end
      PARITY: begin
        if (!rx_en)         state_nxt_s = IDLE;
        else if (fall_s)    state_nxt_s = STOP;
        else if (timeout_s) state_nxt_s = IDLE;
        else                state_nxt_s = PARITY;
      end
      STOP: begin
        if (!rx_en || fall_s || timeout_s) state_nxt_s = IDLE;
        else                               state_nxt_s = STOP;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Frame datapath and error classification.
  always_comb begin
    shift_nxt_s   = shift_r;
    bit_cnt_nxt_s = bit_cnt_r;
    perr_nxt_s    = 1'b0;
    ferr_nxt_s    = 1'b0;
    good_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (rx_en && fall_s && !data_sync_r) begin
          shift_nxt_s   = 8'h00;
          bit_cnt_nxt_s = 3'd0;
        end else if (rx_en && fall_s) begin
          ferr_nxt_s = 1'b1;
        end else begin
          ferr_nxt_s = 1'b0;
        end
      end
      DATA: begin
        if (rx_en && fall_s) begin
          shift_nxt_s   = {data_sync_r, shift_r[7:1]};
          bit_cnt_nxt_s = bit_cnt_r + 3'd1;
        end else if (rx_en && timeout_s) begin
          ferr_nxt_s = 1'b1;
        end else begin
          ferr_nxt_s = 1'b0;
        end
      end
      PARITY: ferr_nxt_s = rx_en && !fall_s && timeout_s;
      STOP: begin
        if (rx_en && fall_s && !data_sync_r)       ferr_nxt_s = 1'b1;
        else if (rx_en && fall_s && parity_bad_s)  perr_nxt_s = 1'b1;
        else if (rx_en && fall_s)                  good_s     = 1'b1;
        else if (rx_en && timeout_s)               ferr_nxt_s = 1'b1;
        else                                       good_s     = 1'b0;
      end
      default: ferr_nxt_s = 1'b0;
    endcase

    if (state_r == IDLE || state_nxt_s == IDLE || fall_s) timer_nxt_s = {TW{1'b0}};
    else                                                  timer_nxt_s = timer_r + TW'(1);
  end

  // Delivery: a concurrent handshake frees the slot for the new byte, otherwise it is an overrun.
  always_comb begin
    data_nxt_s  = data_r;
    valid_nxt_s = valid_r;
    ovr_nxt_s   = 1'b0;
    if (good_s && (!valid_r || ready)) begin
      data_nxt_s  = shift_r;
      valid_nxt_s = 1'b1;
    end else if (good_s) begin
      ovr_nxt_s = 1'b1;
    end else if (valid_r && ready) begin
      valid_nxt_s = 1'b0;
    end else begin
      valid_nxt_s = valid_r;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_r   <= 8'h00;
      bit_cnt_r <= 3'd0;
      timer_r   <= {TW{1'b0}};
      data_r    <= 8'h00;
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
      perr_r    <= 1'b0;
      ferr_r    <= 1'b0;
      ovr_r     <= 1'b0;
    end else begin
      shift_r   <= shift_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      timer_r   <= timer_nxt_s;
      data_r    <= data_nxt_s;
      valid_r   <= valid_nxt_s;
      busy_r    <= (state_nxt_s != IDLE);
      perr_r    <= perr_nxt_s;
      ferr_r    <= ferr_nxt_s;
      ovr_r     <= ovr_nxt_s;
    end
  end

  assign data       = data_r;
  assign valid      = valid_r;
  assign busy       = busy_r;
  assign parity_err = perr_r;
  assign frame_err  = ferr_r;
  assign overrun    = ovr_r;

endmodule

// File: doc/ps2_rx_ctrl.md
# ps2_rx_ctrl

- Receive-side controller for the PS/2 port: synchronizes the device's ps2_clk/ps2_data lines and detects falling edges of ps2_clk.
- Sequences an internal 8-bit shift register through the 11-bit frame: start, 8 data LSB-first, odd parity, stop.
- Validates each frame and hands completed bytes to the scan-code logic over a valid/ready handshake.
- Sits between the PS/2 pins and the keyboard decoder.

## Interface
- TIMEOUT_CYCLES, 5000, max clk cycles allowed between ps2_clk falling edges inside a frame (100 us at 50 MHz).
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock from device, asynchronous to clk.
- ps2_data  in  1  raw PS/2 data from device, asynchronous to clk.
- rx_en  in  1  receive enable; low holds FSM in IDLE.
- ready  in  1  consumer accepts data this cycle.
- data  out  8  received byte; stable while valid=1.
- valid  out  1  byte available.
- busy  out  1  high in any state except IDLE.
- parity_err  out  1  one-cycle pulse: parity mismatch.
- frame_err  out  1  one-cycle pulse: bad start bit, bad stop bit, or timeout.
- overrun  out  1  one-cycle pulse: good frame dropped because valid=1 and ready=0.

## Operation
- Sync: two flops each on ps2_clk and ps2_data, reset to 1. Edge flop holds the previous synced ps2_clk.
- fall = prev_sync_clk & ~sync_clk. All bit sampling uses sync_data in the fall cycle.
- FSM states and transitions:
  - IDLE: on fall with rx_en=1:
    - sync_data=0 -> DATA, bit_cnt=0.
    - sync_data=1 -> frame_err pulse, stay IDLE.
  - DATA: on fall, shift sync_data into bit 7 (right shift, LSB-first) and increment bit_cnt 3-bit. At bit_cnt=7 -> PARITY.
  - PARITY: on fall, latch parity bit -> STOP.
  - STOP: on fall:
    - sync_data=0 -> frame_err pulse, discard.
    - Else if parity fails (see Configuration) -> parity_err pulse, discard.
    - Else deliver. Always -> IDLE.
- Parity ok when XOR(shift[7:0], parity_bit)=1 (odd).
- Deliver:
  - If valid=0, or valid=1 and ready=1 in the same cycle: data<=shift, valid<=1.
  - If valid=1 and ready=0: keep old data, overrun pulse.
- Handshake: valid=1 and ready=1 at a rising edge clears valid next cycle unless a delivery occurs that same edge, in which case valid stays 1 with the new data.
- Timeout: counter cleared in IDLE and on every fall. Increments otherwise while busy. Reaching TIMEOUT_CYCLES-1 -> frame_err pulse, IDLE, partial byte discarded. Counter width $clog2(TIMEOUT_CYCLES).
- rx_en falling mid-frame: next cycle IDLE, no error pulse, valid/data untouched.
- Error pulses are mutually exclusive per frame. At most one of parity_err/frame_err/overrun fires per cycle.

## Timing
- Reset (async assert, sync release): state IDLE, data=8'h00, valid=0, busy=0, parity_err=0, frame_err=0, overrun=0, shift=0, counters=0, sync/edge flops=1 (no false edge after reset).
- Latency: pin fall to fall-detect = 3 clk. Stop-bit fall-detect to valid=1 = 1 clk. busy rises 1 clk after start fall-detect and drops 1 clk after stop fall-detect.
- ps2_clk low/high phases must be ≥3 clk each to be resolved (spec minimum of the PS/2 device is far above this).
- Reset asserted mid-frame: immediate return to reset values; partial frame lost.

## Configuration
- PS2_RX_PARITY_CHECK_EN defined: parity checked as above; failing frames dropped with parity_err pulse.
- Undefined: parity bit sampled but ignored; parity_err tied 0; any frame with correct start/stop bits delivered.

## Test plan
- ps2_clk period 20 clk; frame for 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) with ready=0 -> valid=1, data=8'h1C 1 clk after stop fall-detect, no error pulses. Then ready=1 for 1 clk -> valid=0 next cycle.
- Frame 0xF0 with parity 0 -> with PARITY_CHECK_EN: parity_err one pulse, valid stays 0. Without it: data=8'hF0, valid=1.
- Stop bit driven 0 on 0x1C frame -> frame_err pulse, valid=0, FSM IDLE. A following good 0x1C frame is received correctly.
- ps2_clk stops after 4 data bits for 6000 clk -> frame_err pulse at 4999 cycles after last fall, busy=0. Next good frame 0xF0 delivered.
- Two back-to-back frames 0x1C then 0xF0 with ready=0 -> data stays 8'h1C, overrun pulse at second stop. Repeat with ready=1 held in the delivery cycle -> data=8'hF0, valid stays 1, no overrun.
- reset=0 for 2 clk during bit 5 of a frame -> all outputs at reset values. Remaining edges of the broken frame yield frame_err or nothing, never valid. A fresh frame 0x1C is then received.
